// File: rtl/qsfp_mgmt_ctrl.sv
// QSFP28 low-speed management: ModPrsL debounce, timed reset/init sequencing, per-port pin control.
// Define QSFP_MGMT_INT_EN to build the IntL synchronisers, int_pending latches and irq.
module qsfp_mgmt_ctrl #(
  parameter int unsigned PORTS           = 1,
  parameter int unsigned RESET_CYCLES    = 2000,
  parameter int unsigned INIT_CYCLES     = 400000,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [PORTS-1:0] enable_i,
  input  logic [PORTS-1:0] lpmode_req_i,
  input  logic [PORTS-1:0] modprsl_i,
  input  logic [PORTS-1:0] intl_i,
  input  logic [PORTS-1:0] int_clear_i,
  output logic [PORTS-1:0] resetl_o,
  output logic [PORTS-1:0] modsell_o,
  output logic [PORTS-1:0] lpmode_o,
  output logic [PORTS-1:0] present_o,
  output logic [PORTS-1:0] port_ready_o,
  output logic [PORTS-1:0] int_pending_o,
  output logic             irq_o
);

  localparam int unsigned MaxCycles = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
  localparam int unsigned TmrW      = $clog2(MaxCycles + 1);
  localparam int unsigned DbW       = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TmrW-1:0] ResetLoad = TmrW'(RESET_CYCLES);
  localparam logic [TmrW-1:0] InitLoad  = TmrW'(INIT_CYCLES);
  localparam logic [DbW-1:0]  DbMax     = DbW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {StAbsent, StReset, StInit, StReady} state_e;

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    logic            prs_s1_q, prs_s2_q;
    logic            present_q, present_d;
    logic [DbW-1:0]  db_q, db_d;
    state_e          state_q, state_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            resetl_q, resetl_d;
    logic            modsell_q, modsell_d;
    logic            lpmode_q, lpmode_d;
    logic            ready_q, ready_d;
    logic            drop;

    // Synchronised presence is kept active-high so the reset value means "absent".
    always_comb begin
      db_d      = '0;
      present_d = present_q;
      if (prs_s2_q != present_q) begin
        if (db_q == DbMax) begin
          present_d = ~present_q;
        end else begin
          db_d = db_q + DbW'(1);
        end
      end
    end

    assign drop = !present_q || !enable_i[i];

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      unique case (state_q)
        StAbsent: begin
          if (present_q && enable_i[i]) begin
            state_d = StReset;
            tmr_d   = ResetLoad;
          end
        end
        StReset: begin
          if (drop) begin
            state_d = StAbsent;
          end else if (tmr_q == TmrW'(1)) begin
            state_d = StInit;
            tmr_d   = InitLoad;
          end else begin
            tmr_d = tmr_q - TmrW'(1);
          end
        end
        StInit: begin
          if (drop) begin
            state_d = StAbsent;
          end else if (tmr_q == TmrW'(1)) begin
            state_d = StReady;
          end else begin
            tmr_d = tmr_q - TmrW'(1);
          end
        end
        StReady: begin
          if (drop) begin
            state_d = StAbsent;
          end
        end
        default: state_d = StAbsent;
      endcase

      // Pin values are decoded from the next state so every output leaves a flop.
      resetl_d  = 1'b0;
      modsell_d = 1'b1;
      lpmode_d  = 1'b1;
      ready_d   = 1'b0;
      unique case (state_d)
        StInit: resetl_d = 1'b1;
        StReady: begin
          resetl_d  = 1'b1;
          modsell_d = 1'b0;
          lpmode_d  = lpmode_req_i[i];
          ready_d   = 1'b1;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        prs_s1_q  <= 1'b0;
        prs_s2_q  <= 1'b0;
        present_q <= 1'b0;
        db_q      <= '0;
        state_q   <= StAbsent;
        tmr_q     <= '0;
        resetl_q  <= 1'b0;
        modsell_q <= 1'b1;
        lpmode_q  <= 1'b1;
        ready_q   <= 1'b0;
      end else begin
        prs_s1_q  <= ~modprsl_i[i];
        prs_s2_q  <= prs_s1_q;
        present_q <= present_d;
        db_q      <= db_d;
        state_q   <= state_d;
        tmr_q     <= tmr_d;
        resetl_q  <= resetl_d;
        modsell_q <= modsell_d;
        lpmode_q  <= lpmode_d;
        ready_q   <= ready_d;
      end
    end

    assign resetl_o[i]     = resetl_q;
    assign modsell_o[i]    = modsell_q;
    assign lpmode_o[i]     = lpmode_q;
    assign present_o[i]    = present_q;
    assign port_ready_o[i] = ready_q;

`ifdef QSFP_MGMT_INT_EN
    logic int_s1_q, int_s2_q, int_s3_q;
    logic pend_q, pend_d;

    // A new event wins over a coincident clear.
    always_comb begin
      pend_d = pend_q & ~int_clear_i[i];
      if ((int_s3_q && !int_s2_q && state_q == StReady) || (present_d != present_q)) begin
        pend_d = 1'b1;
      end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        int_s1_q <= 1'b1;
        int_s2_q <= 1'b1;
        int_s3_q <= 1'b1;
        pend_q   <= 1'b0;
      end else begin
        int_s1_q <= intl_i[i];
        int_s2_q <= int_s1_q;
        int_s3_q <= int_s2_q;
        pend_q   <= pend_d;
      end
    end

    assign int_pending_o[i] = pend_q;
`endif
  end

`ifdef QSFP_MGMT_INT_EN
  logic irq_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |int_pending_o;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_int;
  assign unused_int    = ^{intl_i, int_clear_i};
  assign int_pending_o = '0;
  assign irq_o         = 1'b0;
`endif

endmodule
